sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter BASE_ADDR, default 32'd1024: CPU byte address mapped to SRAM word 0.
REQ-002 Parameter PHASE_CYCLES, default 2: cycles spent on each 16-bit half-access (legal range 1..15).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wrEn  input  1  CPU MEM-stage write request, held until ready=1.
REQ-006 rdEn  input  1  CPU MEM-stage read request, held until ready=1.
REQ-007 address  input  32  CPU byte address (word-aligned).
REQ-008 writeData  input  32  CPU store data.
REQ-009 readData  output  32  load data, registered.
REQ-010 ready  output  1  low = CPU pipeline must freeze; high = access done or idle.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  18  SRAM halfword address.
REQ-013 SRAM_WE_N  output  1  active-low write strobe.
REQ-014 SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low controls.

Function
REQ-015 FSM states IDLE, LOW, HIGH, DONE, with transitions IDLE->LOW on (rdEn|wrEn), LOW->HIGH after PHASE_CYCLES, HIGH->DONE after PHASE_CYCLES, DONE->IDLE unconditionally.
REQ-016 On IDLE->LOW the block SHALL latch address, writeData and op (write if wrEn, else read); wrEn wins when both are high.
REQ-017 Word index = (address - BASE_ADDR) >> 2, truncated to 17 bits (modulo wrap, no range check); SRAM_ADDR = {index, 0} in LOW and {index, 1} in HIGH.
REQ-018 ready = 1 in IDLE with no request, 0 in IDLE with a request and throughout LOW and HIGH, and 1 in DONE.
REQ-019 Latency: request seen in cycle 0; ready returns high in cycle 2*PHASE_CYCLES+1 (cycle 5 at default).
REQ-020 Write: SRAM_DQ driven with writeData[15:0] in LOW and writeData[31:16] in HIGH; SRAM_WE_N = 0 in every phase cycle except the last cycle of each phase, where it is 1 (data-hold margin).
REQ-021 Read: SRAM_DQ tri-stated and SRAM_OE_N = 0 in LOW/HIGH; SRAM_DQ sampled on the last cycle of LOW into readData[15:0] and on the last cycle of HIGH into readData[31:16].
REQ-022 SRAM_DQ SHALL be high-Z whenever no write phase is active (IDLE, DONE, reads).
REQ-023 SRAM_CE_N, SRAM_UB_N and SRAM_LB_N are tied 0; SRAM_OE_N = 1 during writes and in IDLE and DONE.
REQ-024 readData holds its value until the next read completes; writes leave it unchanged.
REQ-025 Deasserting the request mid-access has no effect; a latched access always completes.
REQ-026 A request present in the cycle after DONE starts a new access, with no idle bubble beyond the IDLE cycle.
REQ-027 Internal phase counter width is 4 bits and it resets to 0 at each phase entry.

Reset
REQ-028 With rst = 1 at a clock edge, the FSM goes to IDLE, the counter to 0, and readData to 0.
REQ-029 During and after reset: SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_DQ high-Z, SRAM_ADDR = 0, and ready = 1 absent a request.
REQ-030 Reset asserted mid-access aborts the access; SRAM contents written by a completed half are left as-is.

Verification
REQ-031 Write sequence: wrEn, address = 1024, writeData = 0xDEADBEEF. Required: SRAM word 0 = 0xBEEF, word 1 = 0xDEAD, and ready high exactly 5 cycles after the request.
REQ-032 Read-back: rdEn, address = 1024 after the REQ-031 write. Required: readData = 0xDEADBEEF in DONE, with ready low for 5 cycles.
REQ-033 Address mapping: write 0x12345678 to address 1036. Required: SRAM_ADDR = 6 (LOW) and 7 (HIGH).
REQ-034 Both enables high: wrEn = rdEn = 1. Required: a write is performed and readData is unchanged.
REQ-035 Reset mid-op: assert rst in cycle 2 of a write. Required: next cycle in IDLE, SRAM_WE_N = 1, DQ high-Z, readData = 0.
REQ-036 Back-to-back: hold rdEn across two consecutive requests with a new address after DONE. Required: two complete 5-cycle accesses with one ready pulse each.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: bridges a 32-bit CPU MEM-stage load/store port onto a
// 16-bit asynchronous SRAM. Each word access is split into a low and a high
// halfword phase, each lasting PHASE_CYCLES clocks. The CPU is stalled via
// ready until the access completes.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR    = 32'd1024,
  parameter int          PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrEn,
  input  logic        rdEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Terminal count of a phase: counter runs 0 .. PHASE_CYCLES-1.
  localparam logic [3:0] PH_LAST = 4'(PHASE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] idx_q;       // SRAM word index of the latched access
  logic [31:0] wdata_q;
  logic        is_wr_q;
  logic [31:0] rdata_q;

  logic        req;
  logic        ph_last;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign req     = wrEn | rdEn;
  assign ph_last = (cnt_q == PH_LAST);

  // State, phase counter, request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 17'd0;
      wdata_q <= 32'd0;
      is_wr_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Capture the whole request on acceptance so the CPU may drop it early.
      if (state_q == S_IDLE && req) begin
        idx_q   <= 17'((address - BASE_ADDR) >> 2);
        wdata_q <= writeData;
        is_wr_q <= wrEn;
      end
      // Read data is taken at the end of each phase, after the SRAM has
      // had the full phase to settle.
      if (!is_wr_q && ph_last) begin
        if (state_q == S_LOW)  rdata_q[15:0]  <= SRAM_DQ;
        if (state_q == S_HIGH) rdata_q[31:16] <= SRAM_DQ;
      end
    end
  end

  // Next-state and phase counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (req) state_d = S_LOW;
      end
      S_LOW: begin
        if (ph_last) begin
          state_d = S_HIGH;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (ph_last) begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // SRAM strobes, address, data drive and CPU handshake from current state.
  always_comb begin
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_ADDR = 18'd0;
    dq_oe     = 1'b0;
    dq_out    = 16'd0;
    unique case (state_q)
      S_IDLE: ready = !req;
      S_LOW: begin
        SRAM_ADDR = {idx_q, 1'b0};
        if (is_wr_q) begin
          dq_oe     = 1'b1;
          dq_out    = wdata_q[15:0];
          // Release WE one cycle early so data is held past the strobe edge.
          SRAM_WE_N = ph_last;
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      S_HIGH: begin
        SRAM_ADDR = {idx_q, 1'b1};
        if (is_wr_q) begin
          dq_oe     = 1'b1;
          dq_out    = wdata_q[31:16];
          SRAM_WE_N = ph_last;
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      S_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign readData  = rdata_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: drives CPU loads/stores into sram_controller, models
// the SRAM on the bus, and checks results against a word-level memory model.
module tb_sram_controller;
  localparam int          P    = 2;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          LAT  = 2 * P + 1;

  logic        clk = 1'b0;
  logic        rst, wrEn, rdEn;
  logic [31:0] address, writeData, readData;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(BASE), .PHASE_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn), .address(address),
    .writeData(writeData), .readData(readData), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N)
  );

  // Halfword SRAM on the bus
  logic [15:0] sram [0:262143];
  logic        clr = 1'b0;
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 262144; i++) sram[i] <= 16'h0;
    end else if (!SRAM_WE_N && !SRAM_CE_N) begin
      sram[SRAM_ADDR] <= SRAM_DQ;
    end
  end
  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N && !SRAM_CE_N) ? sram[SRAM_ADDR] : 16'hzzzz;

  // Word-level reference: word index -> 32-bit contents, plus last load value
  logic [31:0] ref_mem [int];
  logic [31:0] ref_rd;

  function automatic int idx_of(input logic [31:0] a);
    logic [31:0] d;
    d = (a - BASE) / 4;
    return int'(d % 32'd131072);
  endfunction

  function automatic logic [31:0] ref_get(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
  endfunction

  // One CPU access; returns cycle index of ready, halfword addresses seen,
  // and whether the write-strobe pattern matched. drop_at<0 holds request.
  task automatic run_op(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input int drop_at,
                        output int lat, output logic [17:0] a_lo,
                        output logic [17:0] a_hi, output bit we_ok);
    logic exp_we;
    @(negedge clk);
    wrEn = w; rdEn = r; address = a; writeData = d;
    lat = 0; a_lo = '0; a_hi = '0; we_ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (c == 1)     a_lo = SRAM_ADDR;
      if (c == P + 1) a_hi = SRAM_ADDR;
      if (w) begin
        exp_we = !((c >= 1 && c < P) || (c >= P + 1 && c < 2 * P));
        if (SRAM_WE_N !== exp_we) we_ok = 1'b0;
      end
      if (ready === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
      if (c + 1 == drop_at) begin
        wrEn = 1'b0; rdEn = 1'b0;
      end
    end
    wrEn = 1'b0; rdEn = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; address = '0; writeData = '0;
    clr = 1'b1;
    @(posedge clk); @(posedge clk);
    clr = 1'b0;
    @(negedge clk);
    total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else pass_cnt++;
    total_cnt++; if (SRAM_WE_N !== 1'b1) $display("FAIL reset_we_n got %b want 1", SRAM_WE_N); else pass_cnt++;
    total_cnt++; if (SRAM_OE_N !== 1'b1) $display("FAIL reset_oe_n got %b want 1", SRAM_OE_N); else pass_cnt++;
    total_cnt++; if (SRAM_ADDR !== 18'd0) $display("FAIL reset_addr got %h want 0", SRAM_ADDR); else pass_cnt++;
    total_cnt++; if (readData !== 32'd0) $display("FAIL reset_rdata got %h want 0", readData); else pass_cnt++;
    total_cnt++;
    if ({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N} !== 3'b000)
      $display("FAIL reset_ce_ub_lb got %b want 000", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (ready !== 1'b1) $display("FAIL post_reset_ready got %b want 1", ready); else pass_cnt++;
    ref_rd = 32'd0;
  endtask

  task automatic test_write_read;
    int lat; logic [17:0] lo, hi; bit wok;
    run_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, -1, lat, lo, hi, wok);
    ref_mem[idx_of(32'd1024)] = 32'hDEADBEEF;
    total_cnt++; if (lat !== LAT) $display("FAIL wr_latency got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (sram[0] !== 16'hBEEF) $display("FAIL wr_word0 got %h want BEEF", sram[0]); else pass_cnt++;
    total_cnt++; if (sram[1] !== 16'hDEAD) $display("FAIL wr_word1 got %h want DEAD", sram[1]); else pass_cnt++;
    total_cnt++; if (wok !== 1'b1) $display("FAIL wr_we_pattern got %b want 1", wok); else pass_cnt++;
    total_cnt++; if (readData !== ref_rd) $display("FAIL wr_rdata_kept got %h want %h", readData, ref_rd); else pass_cnt++;
    run_op(1'b0, 1'b1, 32'd1024, 32'h0, -1, lat, lo, hi, wok);
    ref_rd = ref_get(idx_of(32'd1024));
    total_cnt++; if (lat !== LAT) $display("FAIL rd_latency got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (readData !== ref_rd) $display("FAIL rd_data got %h want %h", readData, ref_rd); else pass_cnt++;
  endtask

  task automatic test_addr_map;
    int lat; logic [17:0] lo, hi; bit wok;
    run_op(1'b1, 1'b0, 32'd1036, 32'h12345678, -1, lat, lo, hi, wok);
    ref_mem[idx_of(32'd1036)] = 32'h12345678;
    total_cnt++; if (lo !== 18'd6) $display("FAIL map_addr_low got %0d want 6", lo); else pass_cnt++;
    total_cnt++; if (hi !== 18'd7) $display("FAIL map_addr_high got %0d want 7", hi); else pass_cnt++;
    total_cnt++; if (sram[6] !== 16'h5678) $display("FAIL map_word6 got %h want 5678", sram[6]); else pass_cnt++;
    total_cnt++; if (sram[7] !== 16'h1234) $display("FAIL map_word7 got %h want 1234", sram[7]); else pass_cnt++;
  endtask

  task automatic test_both_enables;
    int lat; logic [17:0] lo, hi; bit wok; logic [31:0] d;
    d = $urandom;
    run_op(1'b1, 1'b1, 32'd1040, d, -1, lat, lo, hi, wok);
    ref_mem[idx_of(32'd1040)] = d;
    total_cnt++; if (lat !== LAT) $display("FAIL both_latency got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if ({sram[9], sram[8]} !== d) $display("FAIL both_written got %h want %h", {sram[9], sram[8]}, d); else pass_cnt++;
    total_cnt++; if (readData !== ref_rd) $display("FAIL both_rdata_kept got %h want %h", readData, ref_rd); else pass_cnt++;
  endtask

  task automatic test_abandon;
    int lat; logic [17:0] lo, hi; bit wok; logic [31:0] d;
    d = $urandom;
    run_op(1'b1, 1'b0, 32'd1044, d, 2, lat, lo, hi, wok);
    ref_mem[idx_of(32'd1044)] = d;
    total_cnt++; if (lat !== LAT) $display("FAIL drop_wr_latency got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if ({sram[11], sram[10]} !== d) $display("FAIL drop_wr_data got %h want %h", {sram[11], sram[10]}, d); else pass_cnt++;
    run_op(1'b0, 1'b1, 32'd1044, 32'h0, 2, lat, lo, hi, wok);
    ref_rd = ref_get(idx_of(32'd1044));
    total_cnt++; if (lat !== LAT) $display("FAIL drop_rd_latency got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (readData !== ref_rd) $display("FAIL drop_rd_data got %h want %h", readData, ref_rd); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int lat; logic [17:0] lo, hi; bit wok; logic [31:0] d, old;
    int idx;
    d = $urandom;
    idx = idx_of(32'd1048);
    old = ref_get(idx);
    @(negedge clk); wrEn = 1'b1; address = 32'd1048; writeData = d;  // cycle 0
    @(negedge clk);                                                   // cycle 1
    @(negedge clk); rst = 1'b1; wrEn = 1'b0;                          // cycle 2
    @(negedge clk); #1;
    total_cnt++; if (SRAM_WE_N !== 1'b1) $display("FAIL rstmid_we_n got %b want 1", SRAM_WE_N); else pass_cnt++;
    total_cnt++; if (SRAM_OE_N !== 1'b1) $display("FAIL rstmid_oe_n got %b want 1", SRAM_OE_N); else pass_cnt++;
    total_cnt++; if (readData !== 32'd0) $display("FAIL rstmid_rdata got %h want 0", readData); else pass_cnt++;
    total_cnt++; if (ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", ready); else pass_cnt++;
    total_cnt++; if (SRAM_ADDR !== 18'd0) $display("FAIL rstmid_addr got %h want 0", SRAM_ADDR); else pass_cnt++;
    rst = 1'b0;
    // Only the low half had its strobe before reset.
    ref_mem[idx] = {old[31:16], d[15:0]};
    ref_rd = 32'd0;
    run_op(1'b0, 1'b1, 32'd1048, 32'h0, -1, lat, lo, hi, wok);
    ref_rd = ref_get(idx);
    total_cnt++; if (readData !== ref_rd) $display("FAIL rstmid_partial got %h want %h", readData, ref_rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [11:0] seen, exp_seen;
    logic [31:0] r1, r2;
    seen = '0; exp_seen = '0; r1 = '0; r2 = '0;
    exp_seen[LAT] = 1'b1;
    exp_seen[2 * LAT + 1] = 1'b1;
    @(negedge clk); rdEn = 1'b1; address = 32'd1024;
    for (int c = 0; c < 12; c++) begin
      #1;
      seen[c] = ready;
      if (c == LAT) begin r1 = readData; address = 32'd1036; end
      if (c == 2 * LAT + 1) r2 = readData;
      if (c < 11) @(negedge clk);
    end
    rdEn = 1'b0;
    ref_rd = ref_get(idx_of(32'd1036));
    total_cnt++; if (seen !== exp_seen) $display("FAIL b2b_ready got %b want %b", seen, exp_seen); else pass_cnt++;
    total_cnt++; if (r1 !== ref_get(idx_of(32'd1024))) $display("FAIL b2b_first got %h want %h", r1, ref_get(idx_of(32'd1024))); else pass_cnt++;
    total_cnt++; if (r2 !== ref_rd) $display("FAIL b2b_second got %h want %h", r2, ref_rd); else pass_cnt++;
  endtask

  task automatic test_random;
    int lat; logic [17:0] lo, hi; bit wok;
    logic [31:0] a, d;
    int idx, k;
    bit w;
    for (int n = 0; n < 30; n++) begin
      k = int'($urandom_range(0, 19)) - 4;   // negative k exercises index wrap
      a = BASE + 32'(4 * k);
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      idx = idx_of(a);
      run_op(w, !w, a, d, -1, lat, lo, hi, wok);
      total_cnt++; if (lat !== LAT) $display("FAIL rnd_latency[%0d] got %0d want %0d", n, lat, LAT); else pass_cnt++;
      total_cnt++; if (lo !== 18'(2 * idx)) $display("FAIL rnd_addr_lo[%0d] got %h want %h", n, lo, 18'(2 * idx)); else pass_cnt++;
      total_cnt++; if (hi !== 18'(2 * idx + 1)) $display("FAIL rnd_addr_hi[%0d] got %h want %h", n, hi, 18'(2 * idx + 1)); else pass_cnt++;
      if (w) begin
        ref_mem[idx] = d;
        total_cnt++;
        if ({sram[2 * idx + 1], sram[2 * idx]} !== d)
          $display("FAIL rnd_wr[%0d] got %h want %h", n, {sram[2 * idx + 1], sram[2 * idx]}, d);
        else pass_cnt++;
        total_cnt++; if (wok !== 1'b1) $display("FAIL rnd_we_pattern[%0d] got %b want 1", n, wok); else pass_cnt++;
      end else begin
        ref_rd = ref_get(idx);
      end
      total_cnt++; if (readData !== ref_rd) $display("FAIL rnd_rdata[%0d] got %h want %h", n, readData, ref_rd); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_addr_map;
    test_both_enables;
    test_abandon;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
